// File: rtl/address_counter_n.sv
// WIDTH-bit address counter: load, signed-offset add, +/-STEP, one-cycle visible stage.
// Define ADDRESS_COUNTER_N_SATURATE_EN to clip count/add at the range ends.
module address_counter_n #(
  parameter int WIDTH      = 16,
  parameter int OFFS_WIDTH = 8,
  parameter int STEP       = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  outn,
  input  logic                  loadn,
  input  logic                  cupn,
  input  logic                  cdownn,
  input  logic                  addn,
  input  logic [OFFS_WIDTH-1:0] offs,
  inout  wire  [WIDTH-1:0]      abus,
  output logic                  wrap
);

  localparam logic [WIDTH-1:0] C_STEP = WIDTH'(STEP);

  logic [WIDTH-1:0] r_prim;
  logic [WIDTH-1:0] r_vis;
  logic             r_wrap_p;
  logic             r_wrap;

  logic signed [OFFS_WIDTH-1:0] w_offs_s;
  logic [WIDTH-1:0] w_ext;
  logic [WIDTH-1:0] w_opnd;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_next;
  logic             w_sub;
  logic             w_neg;
  logic             w_arith;
  logic             w_ovf;

  assign w_offs_s = offs;
  assign w_ext    = WIDTH'(w_offs_s);

  always_comb begin
    w_sub   = 1'b0;
    w_neg   = 1'b0;
    w_opnd  = '0;
    w_arith = 1'b0;
    if (!addn) begin
      w_arith = 1'b1;
      w_opnd  = w_ext;
      w_neg   = w_offs_s[OFFS_WIDTH-1];
    end else if (!cupn && cdownn) begin
      w_arith = 1'b1;
      w_opnd  = C_STEP;
    end else if (cupn && !cdownn) begin
      w_arith = 1'b1;
      w_opnd  = C_STEP;
      w_sub   = 1'b1;
    end
  end

  // Negative add in two's complement: missing carry means a borrow.
  always_comb begin
    if (w_sub) begin
      w_sum = {1'b0, r_prim} - {1'b0, w_opnd};
      w_ovf = w_sum[WIDTH];
    end else begin
      w_sum = {1'b0, r_prim} + {1'b0, w_opnd};
      w_ovf = w_neg ? ~w_sum[WIDTH] : w_sum[WIDTH];
    end
  end

`ifdef ADDRESS_COUNTER_N_SATURATE_EN
  always_comb begin
    if (w_ovf)
      w_next = (w_sub || w_neg) ? '0 : '1;
    else
      w_next = w_sum[WIDTH-1:0];
  end
`else
  assign w_next = w_sum[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prim   <= '0;
      r_vis    <= '0;
      r_wrap_p <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_vis    <= r_prim;
      r_wrap   <= r_wrap_p;
      r_wrap_p <= 1'b0;
      if (!loadn) begin
        // Loading while driving the bus would read back our own value.
        if (outn)
          r_prim <= abus;
      end else if (w_arith) begin
        r_prim   <= w_next;
        r_wrap_p <= w_ovf;
      end
    end
  end

  assign abus = outn ? 'z : r_vis;
  assign wrap = r_wrap;

endmodule
